// File: rtl/gen_ping_pong_counter.sv
// gen_ping_pong_counter
//   Bounded up/down counter. In bounce mode it reverses at the bounds (ping-pong).
//   In wrap mode it jumps to the opposite bound (sawtooth).
//   It also supports synchronous load and a one-cycle direction flip.
//   After reset, the first clock edge moves the counter from INIT to RUN and
//   loads out=min.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable     count enable
//   flip       reverse direction this cycle (and step in the new direction)
//   mode       0 = bounce, 1 = wrap
//   load       synchronous load of load_val (clamped to min when out of range)
//   load_val   value to load
//   max, min   inclusive unsigned bounds
//   step       step magnitude (0 behaves as 1)
//   direction  1 = up, 0 = down
//   out        counter value
//   turn       registered pulse, one cycle after a bound reversal or wrap
//   valid      range legal and out inside it (0 while in INIT)
module gen_ping_pong_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             flip,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max,
   input  logic [WIDTH-1:0] min,
   input  logic [WIDTH-1:0] step,
   output logic             direction,
   output logic [WIDTH-1:0] out,
   output logic             turn,
   output logic             valid
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_out;
   logic             r_dir;
   logic             r_turn;

   logic [WIDTH:0]   w_s;
   logic [WIDTH:0]   w_up_sum;
   logic [WIDTH:0]   w_dn_diff;
   logic             w_up_over;
   logic             w_dn_under;
   logic             w_legal;
   logic             w_load_ok;
   logic             w_dir_eff;
   logic [WIDTH-1:0] w_nxt_out;
   logic             w_nxt_dir;
   logic             w_nxt_turn;

   // base + s, saturated at hi; the extra bit keeps the carry visible.
   function automatic logic [WIDTH-1:0] f_up_clamp(
      input logic [WIDTH-1:0] base,
      input logic [WIDTH:0]   s,
      input logic [WIDTH-1:0] hi
   );
      logic [WIDTH:0] sum;
      sum = {1'b0, base} + s;
      return (sum > {1'b0, hi}) ? hi : sum[WIDTH-1:0];
   endfunction

   // base - s, saturated at lo; the top bit of the difference is the borrow.
   function automatic logic [WIDTH-1:0] f_dn_clamp(
      input logic [WIDTH-1:0] base,
      input logic [WIDTH:0]   s,
      input logic [WIDTH-1:0] lo
   );
      logic [WIDTH:0] diff;
      diff = {1'b0, base} - s;
      return (diff[WIDTH] || (diff[WIDTH-1:0] < lo)) ? lo : diff[WIDTH-1:0];
   endfunction

   assign w_s        = (step == '0) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, step};
   assign w_up_sum   = {1'b0, r_out} + w_s;
   assign w_dn_diff  = {1'b0, r_out} - w_s;
   assign w_up_over  = (w_up_sum > {1'b0, max});
   assign w_dn_under = w_dn_diff[WIDTH] || (w_dn_diff[WIDTH-1:0] < min);
   assign w_legal    = (max > min) && (r_out >= min) && (r_out <= max);
   assign w_load_ok  = (load_val >= min) && (load_val <= max);
   // A flip first reverses direction, then the normal step rules apply.
   assign w_dir_eff  = flip ? ~r_dir : r_dir;

   always_comb begin
      w_nxt_out  = r_out;
      w_nxt_dir  = w_dir_eff;
      w_nxt_turn = 1'b0;
      if (!mode) begin
         if (w_dir_eff) begin
            if (r_out == max) begin
               w_nxt_dir  = 1'b0;
               w_nxt_out  = f_dn_clamp(max, w_s, min);
               w_nxt_turn = 1'b1;
            end else begin
               w_nxt_out  = f_up_clamp(r_out, w_s, max);
            end
         end else begin
            if (r_out == min) begin
               w_nxt_dir  = 1'b1;
               w_nxt_out  = f_up_clamp(min, w_s, max);
               w_nxt_turn = 1'b1;
            end else begin
               w_nxt_out  = f_dn_clamp(r_out, w_s, min);
            end
         end
      end else begin
         if (w_dir_eff) begin
            if (w_up_over) begin
               w_nxt_out  = min;
               w_nxt_turn = 1'b1;
            end else begin
               w_nxt_out  = w_up_sum[WIDTH-1:0];
            end
         end else begin
            if (w_dn_under) begin
               w_nxt_out  = max;
               w_nxt_turn = 1'b1;
            end else begin
               w_nxt_out  = w_dn_diff[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_out   <= '0;
         r_dir   <= 1'b1;
         r_turn  <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_state <= ST_RUN;
               r_out   <= min;
               r_dir   <= 1'b1;
               r_turn  <= 1'b0;
            end
            ST_RUN: begin
               r_turn <= 1'b0;
               if (load) begin
                  r_out <= w_load_ok ? load_val : min;
               end else if (enable && w_legal) begin
                  r_out  <= w_nxt_out;
                  r_dir  <= w_nxt_dir;
                  r_turn <= w_nxt_turn;
               end
            end
         endcase
      end
   end

   assign out       = r_out;
   assign direction = r_dir;
   assign turn      = r_turn;
   assign valid     = (r_state == ST_RUN) && w_legal;

endmodule

// File: doc/gen_ping_pong_counter.md
GEN_PING_PONG_COUNTER -- requirements
Module: gen_ping_pong_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter/bound/step width in bits (legal 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  count enable.
REQ-005 SHALL have port flip  input  1  reverse direction this cycle.
REQ-006 SHALL have port mode  input  1  0 = bounce (ping-pong), 1 = wrap (sawtooth).
REQ-007 SHALL have port load  input  1  synchronous load of load_val.
REQ-008 SHALL have port load_val  input  WIDTH  value to load.
REQ-009 SHALL have ports max, min  input  WIDTH  inclusive bounds, unsigned.
REQ-010 SHALL have port step  input  WIDTH  increment magnitude, unsigned.
REQ-011 SHALL have port direction  output  1  1 = up, 0 = down.
REQ-012 SHALL have port out  output  WIDTH  counter value.
REQ-013 SHALL have port turn  output  1  one-cycle pulse after a bound reversal or wrap.
REQ-014 SHALL have port valid  output  1  1 when range legal and out inside it.

Function
REQ-015 SHALL hold state in {INIT, RUN}; INIT entered only by reset; INIT -> RUN on first rising edge with rst_n high, loading out=min, direction=1, regardless of enable.
REQ-016 SHALL define legal = (max > min) && (min <= out <= max), evaluated on current inputs; valid = legal in RUN, 0 in INIT (combinational).
REQ-017 SHALL apply in RUN, per cycle, first match wins: load > !enable > !legal > flip > count.
REQ-018 load: out <= load_val if min <= load_val <= max, else min; direction unchanged; turn 0; no enable required.
REQ-019 !enable: out, direction hold; turn 0; flip ignored.
REQ-020 !legal: out, direction hold; turn 0; counting resumes the cycle after range becomes legal.
REQ-021 SHALL treat step = 0 as step = 1 (effective step s).
REQ-022 SHALL compute all sums/differences in WIDTH+1 bits; no silent modular overflow.
REQ-023 bounce, up: out == max -> direction <= 0, out <= max(max - s, min), turn pulse; else out <= min(out + s, max).
REQ-024 bounce, down: out == min -> direction <= 1, out <= min(min + s, max), turn pulse; else out <= max(out - s, min).
REQ-025 wrap, up: out + s > max -> out <= min, turn pulse; else out <= out + s; direction unchanged.
REQ-026 wrap, down: out - s < min (signed compare) -> out <= max, turn pulse; else out <= out - s.
REQ-027 flip (enabled, legal): direction <= ~direction and out advances one effective step in the NEW direction per REQ-023..026 rules; turn 0 unless a bound is hit.
REQ-028 turn SHALL be registered, high exactly one cycle after the edge that caused it.
REQ-029 mode, min, max, step changes SHALL take effect on the next edge with no extra latency.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force state=INIT, out=0, direction=1, turn=0; held while rst_n low, including mid-count.
REQ-031 First edge after rst_n rises SHALL execute REQ-015 only; load/flip ignored on that edge.

Verification
REQ-032 WIDTH=4, min=1,max=15,step=1,mode=0: reset release -> out 1; 14 enabled edges -> 15; next -> 14, direction 0, turn 1 for one cycle.
REQ-033 min=0,max=10,step=4,mode=0 -> out sequence 0,4,8,10,6,2,0,4 with turn after 10 and after 0.
REQ-034 min=2,max=9,step=3,mode=1 -> 2,5,8,2(turn),5; step=0 -> counts by 1.
REQ-035 out=3, min raised to 5 -> out holds 3, valid 0; load_val=7 with load -> out 7, valid 1, counting resumes.
REQ-036 out=6 up, step 1, flip -> out 5, direction 0; flip with enable=0 -> no change; flip at out=max going up -> out max-1, direction 0.
REQ-037 rst_n pulsed low between edges mid-count -> out 0, direction 1 without clock edge; next edge -> out=min.
